// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared opcodes, format codes and skid buffer state encoding
package imm_pkg;

   // Base opcodes that carry an immediate
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Immediate format code as presented on out_fmt
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

   // Skid buffer occupancy: the state is the entry count
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate decode and sign extension
//
// Ports:
//   i_instr    32-bit instruction word
//   o_imm      immediate sign-extended from i_instr[31] to XLEN
//   o_fmt      format code (NONE for unrecognised opcodes, imm then 0)
//   o_illegal  unrecognised opcode or i_instr[1:0] != 2'b11
//              (present only with IMMGEN_ILLEGAL_EN)
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output fmt_e            o_fmt
`ifdef IMMGEN_ILLEGAL_EN
   ,
   output logic            o_illegal
`endif
);

   logic [31:0] w_imm32;

   always_comb begin
      o_fmt = FMT_NONE;
      case (i_instr[6:0])
         OP_LOAD, OP_OP_IMM, OP_JALR: o_fmt = FMT_I;
         OP_STORE:                    o_fmt = FMT_S;
         OP_BRANCH:                   o_fmt = FMT_B;
         OP_LUI, OP_AUIPC:            o_fmt = FMT_U;
         OP_JAL:                      o_fmt = FMT_J;
         default:                     o_fmt = FMT_NONE;
      endcase
   end

   // Every format is first built as a 32-bit value sign-extended from bit 31,
   // then widened as a signed quantity so XLEN=64 extends the same sign bit.
   always_comb begin
      w_imm32 = 32'd0;
      case (o_fmt)
         FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
         FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
         FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));

`ifdef IMMGEN_ILLEGAL_EN
   assign o_illegal = (o_fmt == FMT_NONE) || (i_instr[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
//
// Optional feature macro: IMMGEN_ILLEGAL_EN (adds out_illegal and per-entry bit)
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     instruction present          in_ready   can accept this cycle
//   in_instr     32-bit instruction word
//   out_valid    result present               out_ready  consumer takes result
//   out_imm      sign-extended immediate (XLEN bits)
//   out_fmt      format code NONE/I/S/B/U/J = 0..5
//   out_illegal  opcode not recognised (IMMGEN_ILLEGAL_EN only)
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt
`ifdef IMMGEN_ILLEGAL_EN
   ,
   output logic            out_illegal
`endif
);

   buf_state_e      r_state, w_state_nxt;
   logic [XLEN-1:0] w_dec_imm;
   fmt_e            w_dec_fmt;
   logic            w_accept, w_pop;

   // Entry 0 is always the head; entry 1 only holds data in FULL
   logic [XLEN-1:0] r_imm0, r_imm1;
   fmt_e            r_fmt0, r_fmt1;
`ifdef IMMGEN_ILLEGAL_EN
   logic            w_dec_ill;
   logic            r_ill0, r_ill1;
`endif

   imm_extract #(.XLEN(XLEN)) u_extract (
      .i_instr   (in_instr),
      .o_imm     (w_dec_imm),
      .o_fmt     (w_dec_fmt)
`ifdef IMMGEN_ILLEGAL_EN
      ,
      .o_illegal (w_dec_ill)
`endif
   );

   assign w_accept = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Handshake outputs come from the registered state only
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b1;
      out_valid   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) w_state_nxt = ST_ONE;
         end
         ST_ONE: begin
            out_valid = 1'b1;
            if (w_accept && !w_pop)      w_state_nxt = ST_FULL;
            else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            if (w_pop) w_state_nxt = ST_ONE;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_imm0 <= '0;
         r_imm1 <= '0;
         r_fmt0 <= FMT_NONE;
         r_fmt1 <= FMT_NONE;
`ifdef IMMGEN_ILLEGAL_EN
         r_ill0 <= 1'b0;
         r_ill1 <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_imm0 <= w_dec_imm;
                  r_fmt0 <= w_dec_fmt;
`ifdef IMMGEN_ILLEGAL_EN
                  r_ill0 <= w_dec_ill;
`endif
               end
            end
            ST_ONE: begin
               // Accept with pop replaces the head; accept alone queues behind it
               if (w_accept && w_pop) begin
                  r_imm0 <= w_dec_imm;
                  r_fmt0 <= w_dec_fmt;
`ifdef IMMGEN_ILLEGAL_EN
                  r_ill0 <= w_dec_ill;
`endif
               end else if (w_accept) begin
                  r_imm1 <= w_dec_imm;
                  r_fmt1 <= w_dec_fmt;
`ifdef IMMGEN_ILLEGAL_EN
                  r_ill1 <= w_dec_ill;
`endif
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  r_imm0 <= r_imm1;
                  r_fmt0 <= r_fmt1;
`ifdef IMMGEN_ILLEGAL_EN
                  r_ill0 <= r_ill1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign out_imm = r_imm0;
   assign out_fmt = r_fmt0;
`ifdef IMMGEN_ILLEGAL_EN
   assign out_illegal = r_ill0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64)
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = 32'd0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, in_ready64, out_valid64;
   logic [31:0] out_imm;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt, out_fmt64;
`ifdef IMMGEN_ILLEGAL_EN
   logic        out_illegal, out_illegal64;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt)
`ifdef IMMGEN_ILLEGAL_EN
      , .out_illegal(out_illegal)
`endif
   );

   imm_gen_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_fmt(out_fmt64)
`ifdef IMMGEN_ILLEGAL_EN
      , .out_illegal(out_illegal64)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [6:0] op);
      return {imm, 5'd3, 3'd0, 5'd4, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm);
      return {imm[11:5], 5'd5, 5'd6, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd7, 5'd8, 3'b001, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] up, input logic [6:0] op);
      return {up, 5'd9, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   vec_t vecs[15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] bp_instr[4];
      logic [63:0] bp_exp[4];
      logic [63:0] got[8];
      int          k, n_out, cyc;
      logic        acc;

      vecs[0]  = '{enc_i(12'h0F0, 7'b0000011), 3'd1, 64'h0000_0000_0000_00F0, 1'b0};
      vecs[1]  = '{enc_i(12'hF0F, 7'b0000011), 3'd1, 64'hFFFF_FFFF_FFFF_FF0F, 1'b0};
      vecs[2]  = '{enc_s(12'h8C0),             3'd2, 64'hFFFF_FFFF_FFFF_F8C0, 1'b0};
      vecs[3]  = '{enc_s(12'h007),             3'd2, 64'h0000_0000_0000_0007, 1'b0};
      vecs[4]  = '{enc_b(13'h0C14),            3'd3, 64'h0000_0000_0000_0C14, 1'b0};
      vecs[5]  = '{enc_b(13'h1000),            3'd3, 64'hFFFF_FFFF_FFFF_F000, 1'b0};
      vecs[6]  = '{enc_j(21'h1FFFFE),          3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[7]  = '{enc_j(21'h0ABCDE),          3'd5, 64'h0000_0000_000A_BCDE, 1'b0};
      vecs[8]  = '{enc_u(20'h80000, 7'b0110111), 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0};
      vecs[9]  = '{enc_u(20'h12345, 7'b0010111), 3'd4, 64'h0000_0000_1234_5000, 1'b0};
      vecs[10] = '{enc_i(12'h7FF, 7'b1100111), 3'd1, 64'h0000_0000_0000_07FF, 1'b0};
      vecs[11] = '{enc_i(12'h800, 7'b0010011), 3'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0};
      vecs[12] = '{32'hFFFF_F000,              3'd0, 64'h0, 1'b1};
      vecs[13] = '{32'h8765_437F,              3'd0, 64'h0, 1'b1};
      vecs[14] = '{32'hFFFF_FF92,              3'd0, 64'h0, 1'b1};

      // Reset state
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_imm", out_imm, 0);
      check("rst_out_fmt", out_fmt, 0);
`ifdef IMMGEN_ILLEGAL_EN
      check("rst_out_illegal", out_illegal, 0);
`endif
      step();
      rst_n = 1'b1;
      step();

      // Table: one instruction, check result, check it drains
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_instr = vecs[i].instr;
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_imm32", i), out_imm, {32'd0, vecs[i].imm[31:0]});
         check($sformatf("vec%0d_fmt", i), out_fmt, vecs[i].fmt);
         check($sformatf("vec%0d_imm64", i), out_imm64, vecs[i].imm);
         check($sformatf("vec%0d_fmt64", i), out_fmt64, vecs[i].fmt);
         check($sformatf("vec%0d_valid64", i), out_valid64, 1);
`ifdef IMMGEN_ILLEGAL_EN
         check($sformatf("vec%0d_ill", i), out_illegal, vecs[i].ill);
         check($sformatf("vec%0d_ill64", i), out_illegal64, vecs[i].ill);
`endif
         step();
         check($sformatf("vec%0d_drained", i), out_valid, 0);
         check($sformatf("vec%0d_ready64", i), in_ready64, 1);
      end

      // Backpressure: four back-to-back offers while the consumer stalls
      for (int j = 0; j < 4; j++) begin
         bp_instr[j] = enc_i(12'h101 + 12'(j), 7'b0000011);
         bp_exp[j]   = 64'h101 + 64'(j);
      end
      out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         in_instr = bp_instr[k];
         in_valid = 1'b1;
         acc = in_ready;
         step();
         if (acc) k++;
         check("bp_head_stable", out_imm, bp_exp[0]);
      end
      check("bp_accepted", 64'(k), 2);
      check("bp_in_ready_full", in_ready, 0);
      check("bp_out_valid_full", out_valid, 1);

      out_ready = 1'b1;
      n_out = 0;
      cyc = 0;
      while ((k < 4 || n_out < 4) && cyc < 20) begin
         if (k < 4) begin
            in_instr = bp_instr[k];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (n_out < 8) got[n_out] = {32'd0, out_imm};
            n_out++;
         end
         step();
         if (acc) k++;
         cyc++;
      end
      in_valid = 1'b0;
      check("bp_timeout", 64'(cyc < 20), 1);
      check("bp_out_count", 64'(n_out), 4);
      check("bp_no_dup", out_valid, 0);
      for (int j = 0; j < 4; j++)
         if (j < n_out) check($sformatf("bp_order%0d", j), got[j], bp_exp[j]);

      // Simultaneous accept and pop while holding one entry
      out_ready = 1'b0;
      in_instr = enc_i(12'h200, 7'b0010011);
      in_valid = 1'b1;
      step();
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_instr = enc_i(12'h200 + 12'(i), 7'b0010011);
         check($sformatf("one%0d_in_ready", i), in_ready, 1);
         check($sformatf("one%0d_out_valid", i), out_valid, 1);
         check($sformatf("one%0d_imm", i), out_imm, 64'h200 + 64'(i - 1));
         step();
      end
      in_valid = 1'b0;
      check("one_last_imm", out_imm, 64'h20A);
      check("one_last_valid", out_valid, 1);
      step();
      check("one_drained", out_valid, 0);

      // Asynchronous reset with a full buffer
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_instr = enc_s(12'h8C0);
      step();
      in_instr = enc_s(12'h007);
      step();
      in_valid = 1'b0;
      check("rstfull_in_ready", in_ready, 0);
      check("rstfull_out_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstasync_out_valid", out_valid, 0);
      check("rstasync_in_ready", in_ready, 1);
      check("rstasync_out_imm", out_imm, 0);
      check("rstasync_out_fmt", out_fmt, 0);
      check("rstasync_out_valid64", out_valid64, 0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("rstrel%0d_no_output", c), out_valid, 0);
      end
      in_instr = enc_j(21'h1FFFFE);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("rstrel_new_valid", out_valid, 1);
      check("rstrel_new_imm", out_imm, 64'hFFFF_FFFE);
      check("rstrel_new_fmt", out_fmt, 3'd5);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
